// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and phase helpers for the VGA timing block.
package vga_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} vga_phase_t;

    localparam int unsigned VGA_DIV_NUM  = 4;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Length of a phase, in pixels or lines depending on the axis.
    function automatic int unsigned phase_len(input vga_phase_t ph, input int unsigned active,
                                              input int unsigned fp, input int unsigned sync,
                                              input int unsigned bp);
        unique case (ph)
            PH_ACTIVE: return active;
            PH_FP:     return fp;
            PH_SYNC:   return sync;
            PH_BP:     return bp;
        endcase
    endfunction

    // Raster order of the four phases.
    function automatic vga_phase_t phase_next(input vga_phase_t ph);
        unique case (ph)
            PH_ACTIVE: return PH_FP;
            PH_FP:     return PH_SYNC;
            PH_SYNC:   return PH_BP;
            PH_BP:     return PH_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock-enable: one-clk tick every P_DIV_NUM clks while enabled.
module pix_ce_gen #(
    parameter int unsigned P_DIV_NUM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CW = (P_DIV_NUM > 1) ? $clog2(P_DIV_NUM) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(P_DIV_NUM - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the last count; disabling clears the divider so restart is phase-aligned.
    always_comb begin
        o_tick = i_en && (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        if (!i_en || o_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: H/V phase FSMs advanced by a pixel clock-enable, registered outputs.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned P_DIV_NUM  = VGA_DIV_NUM,
    parameter int unsigned P_H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned P_H_FP     = VGA_H_FP,
    parameter int unsigned P_H_SYNC   = VGA_H_SYNC,
    parameter int unsigned P_H_BP     = VGA_H_BP,
    parameter int unsigned P_V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned P_V_FP     = VGA_V_FP,
    parameter int unsigned P_V_SYNC   = VGA_V_SYNC,
    parameter int unsigned P_V_BP     = VGA_V_BP,
    parameter bit          P_HS_POL   = 1'b0,
    parameter bit          P_VS_POL   = 1'b0,
    localparam int unsigned H_TOTAL   = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP,
    localparam int unsigned V_TOTAL   = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP,
    localparam int unsigned XW        = $clog2(H_TOTAL),
    localparam int unsigned YW        = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic          o_pix_ce,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    if (P_DIV_NUM < 1 || P_H_ACTIVE < 1 || P_H_FP < 1 || P_H_SYNC < 1 || P_H_BP < 1 ||
        P_V_ACTIVE < 1 || P_V_FP < 1 || P_V_SYNC < 1 || P_V_BP < 1) begin : g_bad_params
        $error("vga_timing_ctrl: divider and every phase length must be >= 1");
    end

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    logic tick;

    pix_ce_gen #(
        .P_DIV_NUM(P_DIV_NUM)
    ) u_pix_ce_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (i_en),
        .o_tick(tick)
    );

    // Axis state describes the pixel/line that the next tick will emit.
    vga_phase_t    h_ph_q, h_ph_d, v_ph_q, v_ph_d;
    logic [XW-1:0] h_cnt_q, h_cnt_d, h_x_q, h_x_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d, v_y_q, v_y_d;
    logic          h_wrap, v_adv;

    assign h_wrap = (h_x_q == X_LAST);
    assign v_adv  = tick && h_wrap;

    // Horizontal FSM: per-phase down-counter, position counter wraps at end of line.
    always_comb begin
        h_ph_d  = h_ph_q;
        h_cnt_d = h_cnt_q;
        h_x_d   = h_x_q;
        if (!i_en) begin
            h_ph_d  = PH_ACTIVE;
            h_cnt_d = XW'(P_H_ACTIVE - 1);
            h_x_d   = '0;
        end else if (tick) begin
            h_x_d = h_wrap ? '0 : h_x_q + XW'(1);
            if (h_cnt_q == '0) begin
                h_ph_d  = phase_next(h_ph_q);
                h_cnt_d = XW'(phase_len(phase_next(h_ph_q), P_H_ACTIVE, P_H_FP, P_H_SYNC,
                                        P_H_BP) - 1);
            end else begin
                h_cnt_d = h_cnt_q - XW'(1);
            end
        end
    end

    // Vertical FSM: same pattern in lines, stepped only at end of line.
    always_comb begin
        v_ph_d  = v_ph_q;
        v_cnt_d = v_cnt_q;
        v_y_d   = v_y_q;
        if (!i_en) begin
            v_ph_d  = PH_ACTIVE;
            v_cnt_d = YW'(P_V_ACTIVE - 1);
            v_y_d   = '0;
        end else if (v_adv) begin
            v_y_d = (v_y_q == Y_LAST) ? '0 : v_y_q + YW'(1);
            if (v_cnt_q == '0) begin
                v_ph_d  = phase_next(v_ph_q);
                v_cnt_d = YW'(phase_len(phase_next(v_ph_q), P_V_ACTIVE, P_V_FP, P_V_SYNC,
                                        P_V_BP) - 1);
            end else begin
                v_cnt_d = v_cnt_q - YW'(1);
            end
        end
    end

    // Axis state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_ph_q  <= PH_ACTIVE;
            h_cnt_q <= XW'(P_H_ACTIVE - 1);
            h_x_q   <= '0;
            v_ph_q  <= PH_ACTIVE;
            v_cnt_q <= YW'(P_V_ACTIVE - 1);
            v_y_q   <= '0;
        end else begin
            h_ph_q  <= h_ph_d;
            h_cnt_q <= h_cnt_d;
            h_x_q   <= h_x_d;
            v_ph_q  <= v_ph_d;
            v_cnt_q <= v_cnt_d;
            v_y_q   <= v_y_d;
        end
    end

    // Output registers: load the current pixel on tick, hold between ticks, pulses self-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pix_ce      <= 1'b0;
            o_hsync       <= ~P_HS_POL;
            o_vsync       <= ~P_VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (!i_en) begin
            o_pix_ce      <= 1'b0;
            o_hsync       <= ~P_HS_POL;
            o_vsync       <= ~P_VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (tick) begin
            o_pix_ce      <= 1'b1;
            o_hsync       <= (h_ph_q == PH_SYNC) ? P_HS_POL : ~P_HS_POL;
            o_vsync       <= (v_ph_q == PH_SYNC) ? P_VS_POL : ~P_VS_POL;
            o_de          <= (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
            o_x           <= h_x_q;
            o_y           <= v_y_q;
            o_line_start  <= (h_x_q == '0);
            o_frame_start <= (h_x_q == '0) && (v_y_q == '0);
        end else begin
            o_pix_ce      <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: three timing configurations checked every clk against an arithmetic raster model.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    // A: defaults. B: DIV=1 tiny. C: DIV=3, small, active-high syncs.
    logic a_ce, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic b_ce, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [2:0] b_x, b_y;
    logic c_ce, c_hs, c_vs, c_de, c_ls, c_fs;
    logic [3:0] c_x;
    logic [2:0] c_y;

    vga_timing_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_en(en), .o_pix_ce(a_ce), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_de(a_de), .o_x(a_x), .o_y(a_y), .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    vga_timing_ctrl #(
        .P_DIV_NUM(1), .P_H_ACTIVE(4), .P_H_FP(1), .P_H_SYNC(1), .P_H_BP(1),
        .P_V_ACTIVE(2), .P_V_FP(1), .P_V_SYNC(1), .P_V_BP(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_en(en), .o_pix_ce(b_ce), .o_hsync(b_hs), .o_vsync(b_vs),
        .o_de(b_de), .o_x(b_x), .o_y(b_y), .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    vga_timing_ctrl #(
        .P_DIV_NUM(3), .P_H_ACTIVE(5), .P_H_FP(2), .P_H_SYNC(3), .P_H_BP(2),
        .P_V_ACTIVE(3), .P_V_FP(1), .P_V_SYNC(2), .P_V_BP(2), .P_HS_POL(1'b1), .P_VS_POL(1'b1)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .i_en(en), .o_pix_ce(c_ce), .o_hsync(c_hs), .o_vsync(c_vs),
        .o_de(c_de), .o_x(c_x), .o_y(c_y), .o_line_start(c_ls), .o_frame_start(c_fs)
    );

    logic [63:0] a_vec, b_vec, c_vec;
    assign a_vec = {26'b0, a_ce, a_hs, a_vs, a_de, a_ls, a_fs, 16'(a_x), 16'(a_y)};
    assign b_vec = {26'b0, b_ce, b_hs, b_vs, b_de, b_ls, b_fs, 16'(b_x), 16'(b_y)};
    assign c_vec = {26'b0, c_ce, c_hs, c_vs, c_de, c_ls, c_fs, 16'(c_x), 16'(c_y)};

    // Clks elapsed with enable continuously high since the last reset/disable.
    int a_run = 0, b_run = 0, c_run = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            a_run <= 0;
            b_run <= 0;
            c_run <= 0;
        end else begin
            a_run <= a_run + 1;
            b_run <= b_run + 1;
            c_run <= c_run + 1;
        end
    end

    // Expected outputs from the raster rules: pixel n is emitted at clk (n+1)*div.
    function automatic logic [63:0] model(input int run, input int div, input int ha,
                                          input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs,
                                          input int vb, input bit hp, input bit vp);
        int ht, vt, n, x, y;
        bit ce, ls, fs, hsa, vsa, de;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (run < div) return {26'b0, 1'b0, ~hp, ~vp, 3'b000, 32'b0};
        n   = run / div - 1;
        x   = n % ht;
        y   = (n / ht) % vt;
        ce  = (run % div) == 0;
        ls  = ce && (x == 0);
        fs  = ls && (y == 0);
        hsa = (x >= ha + hf) && (x < ha + hf + hs);
        vsa = (y >= va + vf) && (y < va + vf + vs);
        de  = (x < ha) && (y < va);
        return {26'b0, ce, hsa ? hp : ~hp, vsa ? vp : ~vp, de, ls, fs, 16'(x), 16'(y)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-clk comparison of every output of every instance.
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_cycle", a_vec, model(a_run, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0));
            check("b_cycle", b_vec, model(b_run, 1, 4, 1, 1, 1, 2, 1, 1, 1, 0, 0));
            check("c_cycle", c_vec, model(c_run, 3, 5, 2, 3, 2, 3, 1, 2, 2, 1, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From a fresh enable: no tick for 3 clks, pixel 0,0 with frame_start on the 4th.
    task automatic check_first_pixel(input string tag);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, "_no_early_ce"}, 64'(a_ce), 64'd0);
        end
        step();
        check({tag, "_first_pixel"}, {58'b0, a_ce, a_de, a_fs, a_ls, 2'b0} | {a_x, a_y},
              {58'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b0});
    endtask

    localparam logic [63:0] A_RESET = {26'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'b0};

    int ticks, de_cnt, hs_cnt, ls_cnt, fs_cnt, hs_min, hs_max;
    bit found;

    initial begin
        repeat (3) step();
        chk_on = 1'b1;
        check("a_reset_state", a_vec, A_RESET);
        #1 rst_n = 1'b1;
        step();
        check("a_idle_no_en", a_vec, A_RESET);

        en = 1'b1;
        check_first_pixel("a_pwr");

        // One full line of A starting at pixel 0.
        ticks = 0; de_cnt = 0; hs_cnt = 0; ls_cnt = 0; hs_min = 9999; hs_max = -1;
        for (int i = 0; i < 3200; i++) begin
            if (i != 0) step();
            if (a_ce) begin
                ticks++;
                if (a_de) de_cnt++;
                if (a_ls) ls_cnt++;
                if (!a_hs) begin
                    hs_cnt++;
                    if (int'(a_x) < hs_min) hs_min = int'(a_x);
                    if (int'(a_x) > hs_max) hs_max = int'(a_x);
                end
            end
        end
        check("a_line_ticks", 64'(ticks), 64'd800);
        check("a_line_de", 64'(de_cnt), 64'd640);
        check("a_line_hsync_len", 64'(hs_cnt), 64'd96);
        check("a_line_hsync_first", 64'(hs_min), 64'd656);
        check("a_line_hsync_last", 64'(hs_max), 64'd751);
        check("a_line_start_cnt", 64'(ls_cnt), 64'd1);

        // Drop enable at x=700 mid-line; next clk must be reset values.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            found = a_ce && (a_x == 10'd700);
        end
        check("a_reach_x700", 64'(found), 64'd1);
        en = 1'b0;
        step();
        check("a_drop_reset", a_vec, A_RESET);
        en = 1'b1;
        check_first_pixel("a_reen");

        // B: pix_ce every clk, two 35-clk frames give two frame_starts.
        en = 1'b0;
        step();
        en = 1'b1;
        fs_cnt = 0; ticks = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (b_fs) fs_cnt++;
            if (b_ce) ticks++;
        end
        check("b_frame_starts", 64'(fs_cnt), 64'd2);
        check("b_ce_every_clk", 64'(ticks), 64'd70);

        // Random enable bursts and drops; per-clk model compares everything.
        for (int it = 0; it < 150; it++) begin
            en = 1'b1;
            repeat ($urandom_range(1, 400)) step();
            en = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end

        // Async reset in the middle of A's hsync.
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            found = a_ce && (a_x == 10'd700);
        end
        check("a_reach_sync", 64'(found), 64'd1);
        check("a_in_hsync", 64'(a_hs), 64'd0);
        #1 rst_n = 1'b0;
        #1 check("a_async_reset", a_vec, A_RESET);
        step();
        rst_n = 1'b1;
        check_first_pixel("a_post_rst");
        repeat (3300) step();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
